// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state type and bus constants for the APB initiator
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_e;

  localparam logic [15:0] APB_BASE   = 16'h1000;
  localparam int          APB_DATA_W = 32;
  localparam int          PADDR_W    = 12;
  localparam int          IDX_W      = 4;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps the upper request address bits onto a slave index and one-hot select
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4
) (
  input  logic [31:PADDR_W]   req_addr_i,
  output logic                hit_o,
  output logic [IDX_W-1:0]    index_o,
  output logic [NUM_SLV-1:0]  sel_o
);

  always_comb begin
    index_o = req_addr_i[PADDR_W+IDX_W-1:PADDR_W];
    hit_o   = (req_addr_i[31:PADDR_W+IDX_W] == APB_BASE) && (int'(index_o) < NUM_SLV);
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = hit_o && (int'(index_o) == i);
    end
  end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator: valid/ready request port to SETUP/ACCESS transfers on NUM_SLV responders
module apb_master
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [APB_DATA_W-1:0]         req_wdata,
  output logic                          rsp_valid,
  output logic [APB_DATA_W-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [PADDR_W-1:0]            PADDR,
  output logic                          PWRITE,
  output logic [APB_DATA_W-1:0]         PWDATA,
  output logic [NUM_SLV-1:0]            PSEL,
  output logic                          PENABLE,
  input  logic [APB_DATA_W*NUM_SLV-1:0] PRDATA_S,
  input  logic [NUM_SLV-1:0]            PREADY_S
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e              state_q, state_d;
  logic                    write_q, write_d;
  logic [PADDR_W-1:0]      addr_q, addr_d;
  logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_SLV-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [APB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLV-1:0]      dec_sel;
  logic                    slv_ready;
  logic [APB_DATA_W-1:0]   slv_rdata;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV)
  ) u_dec (
    .req_addr_i (req_addr[31:PADDR_W]),
    .hit_o      (dec_hit),
    .index_o    (dec_idx),
    .sel_o      (dec_sel)
  );

  // Only the latched slave's PREADY/PRDATA are visible to the FSM.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (int'(idx_q) == i) begin
        slv_ready = PREADY_S[i];
        slv_rdata = PRDATA_S[APB_DATA_W*i +: APB_DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready   = 1'b0;
    PSEL        = '0;
    PENABLE     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[PADDR_W-1:0];
          wdata_d = req_wdata;
          idx_d   = dec_idx;
          sel_d   = dec_sel;
          if (dec_hit) begin
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ERR;
          end
        end
      end
      SETUP: begin
        PSEL    = sel_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = sel_q;
        PENABLE = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // cnt_q counts ACCESS cycles already spent, so the bus phase lasts at most TIMEOUT cycles
        if (slv_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : slv_rdata;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - bench for apb_master: per-cycle transaction model plus directed transfers
module tb_apb_master;

  localparam int NUM_SLV = 4;
  localparam int TIMEOUT = 8;

  logic                  PCLK;
  logic                  PRESET;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [11:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic [32*NUM_SLV-1:0] PRDATA_S;
  logic [NUM_SLV-1:0]    PREADY_S;

  int tests = 0;
  int fails = 0;
  int scyc  = 0;

  apb_master #(
    .NUM_SLV (NUM_SLV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA_S  (PRDATA_S),
    .PREADY_S  (PREADY_S)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Responders: slave 0 zero-wait, slave 1 never ready, slave 2 three waits, slave 3 one wait.
  // Outside their own ACCESS phase the non-stuck slaves drive PREADY high as noise.
  int wait_cyc [NUM_SLV] = '{0, 0, 3, 1};
  bit stuck    [NUM_SLV] = '{0, 1, 0, 0};
  int acc      [NUM_SLV];

  always @(posedge PCLK) begin
    #2;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i] && PENABLE) acc[i] = acc[i] + 1;
      else acc[i] = 0;
      if (stuck[i]) PREADY_S[i] = 1'b0;
      else if (PSEL[i] && PENABLE) PREADY_S[i] = (acc[i] > wait_cyc[i]);
      else PREADY_S[i] = 1'b1;
    end
  end

  // Transaction model: a request accepted in cycle c occupies the bus from cycle c+1
  // (one SETUP cycle, then ACCESS until the slave is ready or TIMEOUT ACCESS cycles pass);
  // the response appears in the cycle after the bus phase, or in cycle c+1 for a decode miss.
  int          mc = 0;
  bit          tx_on, tx_hit, tx_wr;
  int          tx_a, tx_idx, phase;
  logic [31:0] tx_addr, tx_wdata;
  bit          rsp_due;
  int          rsp_cyc;
  bit          rsp_err_m;
  logic [31:0] rsp_data_m;
  logic [NUM_SLV-1:0] e_psel;
  bit          e_pen, e_ready, e_rv;

  always @(negedge PCLK) begin
    mc++;
    if (!PRESET) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_paddr", 32'(PADDR), 32'd0);
      chk("rst_pwrite", 32'(PWRITE), 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      tx_on   = 1'b0;
      rsp_due = 1'b0;
    end else begin
      e_rv    = rsp_due && (rsp_cyc == mc);
      e_psel  = '0;
      e_pen   = 1'b0;
      e_ready = 1'b1;
      phase   = mc - tx_a;
      if (tx_on) begin
        e_ready = 1'b0;
        if (tx_hit) begin
          e_psel = NUM_SLV'(1) << tx_idx;
          e_pen  = (phase >= 1);
        end
      end
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("m_rsp_err", 32'(rsp_err), 32'(rsp_err_m));
        chk("m_rsp_rdata", rsp_rdata, rsp_data_m);
        rsp_due = 1'b0;
      end
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_psel", 32'(PSEL), 32'(e_psel));
      chk("m_penable", 32'(PENABLE), 32'(e_pen));
      if (tx_on && tx_hit) begin
        chk("m_paddr", 32'(PADDR), tx_addr & 32'hFFF);
        chk("m_pwrite", 32'(PWRITE), 32'(tx_wr));
        chk("m_pwdata", PWDATA, tx_wdata);
      end
      if (tx_on) begin
        if (!tx_hit) begin
          tx_on = 1'b0;
        end else if (phase >= 1) begin
          if (PREADY_S[tx_idx]) begin
            rsp_due    = 1'b1;
            rsp_cyc    = mc + 1;
            rsp_err_m  = 1'b0;
            rsp_data_m = tx_wr ? 32'h0 : PRDATA_S[32*tx_idx +: 32];
            tx_on      = 1'b0;
          end else if (phase == TIMEOUT) begin
            rsp_due    = 1'b1;
            rsp_cyc    = mc + 1;
            rsp_err_m  = 1'b1;
            rsp_data_m = 32'h0;
            tx_on      = 1'b0;
          end
        end
      end
      if (e_ready && req_valid) begin
        tx_on    = 1'b1;
        tx_a     = mc + 1;
        tx_wr    = req_write;
        tx_addr  = req_addr;
        tx_wdata = req_wdata;
        tx_idx   = int'((req_addr >> 12) & 32'hF);
        tx_hit   = ((req_addr >> 16) == 32'h1000) && (tx_idx < NUM_SLV);
        if (!tx_hit) begin
          rsp_due    = 1'b1;
          rsp_cyc    = mc + 1;
          rsp_err_m  = 1'b1;
          rsp_data_m = 32'h0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
    scyc++;
  endtask

  // Presents a request, waits for req_ready, returns in the first cycle after the accepting edge.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_bound", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // lat is the spec cycle number of rsp_valid, counting the cycle after the accepting edge as 1.
  task automatic wait_rsp(output int lat, output logic [31:0] data, output logic err,
                          output int n_setup, output int n_access, output logic [NUM_SLV-1:0] psel_or);
    bit seen = 1'b0;
    lat = 1; n_setup = 0; n_access = 0; psel_or = '0; data = 'x; err = 1'bx;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        data = rsp_rdata;
        err  = rsp_err;
      end else begin
        psel_or = psel_or | PSEL;
        if (|PSEL) begin
          if (PENABLE) n_access++;
          else n_setup++;
        end
        tick();
        lat++;
      end
    end
    chk("rsp_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int lat, ns, na;
    logic [31:0] d;
    logic e;
    logic [NUM_SLV-1:0] por;
    int acc_at [3];
    logic [31:0] pw [3];
    logic [31:0] b2b [3];

    b2b = '{32'hF, 32'h0, 32'hF};
    PRESET    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA_S  = {32'h4444_0000, 32'hA5A5_0001, 32'h2222_0000, 32'h1111_0000};
    repeat (3) tick();
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_psel", 32'(PSEL), 32'd0);
    PRESET = 1'b1;
    tick();

    // zero-wait write to slave 0
    do_req(1'b1, 32'h1000_0004, 32'hF);
    chk("t1_setup_psel", 32'(PSEL), 32'h1);
    chk("t1_setup_penable", 32'(PENABLE), 32'd0);
    chk("t1_paddr", 32'(PADDR), 32'h004);
    chk("t1_pwdata", PWDATA, 32'hF);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t1_rsp_cycle", 32'(lat), 32'd3);
    chk("t1_err", 32'(e), 32'd0);
    chk("t1_setup_cycles", 32'(ns), 32'd1);
    chk("t1_access_cycles", 32'(na), 32'd1);
    chk("t1_psel_seen", 32'(por), 32'h1);

    // read with three wait states from slave 2
    do_req(1'b0, 32'h1000_2000, 32'h0);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t2_access_cycles", 32'(na), 32'd4);
    chk("t2_rdata", d, 32'hA5A5_0001);
    chk("t2_err", 32'(e), 32'd0);
    chk("t2_rsp_cycle", 32'(lat), 32'd6);
    chk("t2_psel_seen", 32'(por), 32'h4);

    // one-wait read from the highest slave
    do_req(1'b0, 32'h1000_3FFC, 32'h0);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t2b_rdata", d, 32'h4444_0000);
    chk("t2b_rsp_cycle", 32'(lat), 32'd4);

    // decode misses: wrong base, and index beyond NUM_SLV
    do_req(1'b0, 32'h2000_0000, 32'h0);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t3_rsp_cycle", 32'(lat), 32'd1);
    chk("t3_err", 32'(e), 32'd1);
    chk("t3_rdata", d, 32'd0);
    chk("t3_psel_seen", 32'(por), 32'd0);
    do_req(1'b1, 32'h1000_5000, 32'h77);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t3b_err", 32'(e), 32'd1);
    chk("t3b_psel_seen", 32'(por), 32'd0);

    // slave 1 never ready: timeout after TIMEOUT ACCESS cycles
    do_req(1'b0, 32'h1000_1000, 32'h0);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t4_access_cycles", 32'(na), 32'd8);
    chk("t4_err", 32'(e), 32'd1);
    chk("t4_rdata", d, 32'd0);
    chk("t4_rsp_cycle", 32'(lat), 32'd10);
    chk("t4_psel_drop", 32'(PSEL), 32'd0);
    chk("t4_penable_drop", 32'(PENABLE), 32'd0);
    do_req(1'b0, 32'h1000_0010, 32'h0);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t4_next_err", 32'(e), 32'd0);
    chk("t4_next_rdata", d, 32'h1111_0000);

    // back-to-back writes with req_valid held
    req_write = 1'b1;
    req_addr  = 32'h1000_0004;
    req_wdata = b2b[0];
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!req_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
      acc_at[k] = scyc;
      pw[k] = PWDATA;
      if (k < 2) req_wdata = b2b[k+1];
      else req_valid = 1'b0;
    end
    wait_rsp(lat, d, e, ns, na, por);
    chk("t5_spacing_01", 32'(acc_at[1] - acc_at[0]), 32'd3);
    chk("t5_spacing_12", 32'(acc_at[2] - acc_at[1]), 32'd3);
    chk("t5_pwdata_0", pw[0], 32'hF);
    chk("t5_pwdata_1", pw[1], 32'h0);
    chk("t5_pwdata_2", pw[2], 32'hF);

    // reset in the middle of an ACCESS phase
    do_req(1'b1, 32'h1000_2008, 32'h55);
    tick();
    tick();
    chk("t6_in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b0;
    #1;
    chk("t6_psel_clr", 32'(PSEL), 32'd0);
    chk("t6_penable_clr", 32'(PENABLE), 32'd0);
    chk("t6_pwdata_clr", PWDATA, 32'd0);
    chk("t6_paddr_clr", 32'(PADDR), 32'd0);
    chk("t6_rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    repeat (3) tick();
    PRESET = 1'b1;
    tick();
    chk("t6_ready_after", 32'(req_ready), 32'd1);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 32'h1000_0004, 32'h3C);
    wait_rsp(lat, d, e, ns, na, por);
    chk("t6_new_rsp_cycle", 32'(lat), 32'd3);
    chk("t6_new_err", 32'(e), 32'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
